// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-PC sequencer feeding ID through a 2-entry queue that hides imem read latency
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_q,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic               misalign
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;
  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d, ipc_q;
  logic        inflight_q, misalign_q;
  logic [1:0]  cnt_q, cnt_d;
  ent_t        e0_q, e0_d, e1_q, e1_d, ent_new;
  logic        pop, enq, ok_redir, bad_redir;
  assign id_valid  = cnt_q != 2'd0;
  assign pop       = id_valid & id_ready;
  assign ok_redir  = redirect & (redirect_pc[1:0] == 2'b00);
  assign bad_redir = redirect & (|redirect_pc[1:0]);
  assign imem_en   = (state_q == RUN) & !redirect
                   & (({1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
  assign imem_addr = fpc_q[IMEM_AW+1:2];
  assign enq       = inflight_q & !redirect;
  assign ent_new   = {ipc_q, ipc_q + 32'd4, imem_q};
  assign id_inst   = e0_q.inst;
  assign id_pc     = e0_q.pc;
  assign id_pc4    = e0_q.pc4;
  assign misalign  = misalign_q;
  assign state_d = ok_redir ? RUN
                 : bad_redir ? HALT
                 : (state_q == BOOT) ? RUN
                 : ((state_q == RUN) & halt) ? HALT
                 : state_q;
  assign fpc_d = ok_redir ? redirect_pc : imem_en ? fpc_q + 32'd4 : fpc_q;
  // pop shifts first so returning data lands in the first free slot after it
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (enq) begin
      if (cnt_d == 2'd0) e0_d = ent_new;
      else e1_d = ent_new;
      cnt_d = cnt_d + 2'd1;
    end
    if (redirect) cnt_d = 2'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      fpc_q      <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
      e0_q       <= '0;
      e1_q       <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      ipc_q      <= fpc_q;
      inflight_q <= imem_en;
      misalign_q <= misalign_q | bad_redir;
      cnt_q      <= cnt_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a pc scoreboard checked by a separate ID-side monitor
module tb_fetch_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        imem_en, id_valid, misalign;
  logic        id_ready = 1'b1, redirect = 1'b0, halt = 1'b0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_q = '0, id_inst, id_pc, id_pc4, redirect_pc = '0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e, last_pc = '0;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  fetch_ctrl #(.RESET_PC(32'h0), .IMEM_AW(10)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_q(imem_q),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .misalign(misalign)
  );
  function automatic logic [31:0] inst_of(input logic [9:0] a);
    return {6'h23, a, 6'h15, ~a};
  endfunction
  always @(posedge clk) if (imem_en) imem_q <= inst_of(imem_addr);
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %h expected no transfer at %0t", id_pc, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", id_pc, mon_e);
        chk("pop_inst", id_inst, inst_of(mon_e[11:2]));
        chk("pop_pc4", id_pc4, mon_e + 32'd4);
        last_pc = id_pc;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask
  task automatic reset_vals();
    chk("rst_en", imem_en, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_inst", id_inst, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_pc4", id_pc4, 0);
    chk("rst_misalign", misalign, 0);
  endtask
  task automatic boot();
    rst = 1'b1;
    #1;
    chk("c0_en", imem_en, 0);
    step(); #1;
    chk("c1_en", imem_en, 1);
    chk("c1_addr", imem_addr, 0);
    step(); #1;
    chk("c2_valid", id_valid, 0);
    step(); #1;
    chk("c3_valid", id_valid, 1);
    chk("c3_pc", id_pc, 0);
    chk("c3_pc4", id_pc4, 4);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_vals();
    restart(32'h0);
    boot();
    step(); step(); step();
    step(); id_ready = 1'b0; #1;
    chk("bp_en", imem_en, 0);
    chk("bp_pc", id_pc, 32'h10);
    repeat (2) begin
      step(); #1;
      chk("bp_hold_pc", id_pc, 32'h10);
      chk("bp_hold_en", imem_en, 0);
      chk("bp_hold_valid", id_valid, 1);
    end
    step(); id_ready = 1'b1;
    step(); step();
    step(); id_ready = 1'b0;
    step(); redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("stall_redir_en", imem_en, 0);
    chk("stall_full_pc", id_pc, 32'h1C);
    step(); redirect = 1'b0; id_ready = 1'b1; restart(32'h100); #1;
    chk("rd_t1_valid", id_valid, 0);
    chk("rd_t1_en", imem_en, 1);
    chk("rd_t1_addr", imem_addr, 10'h40);
    step(); #1;
    chk("rd_t2_valid", id_valid, 0);
    step(); #1;
    chk("rd_t3_valid", id_valid, 1);
    chk("rd_t3_pc", id_pc, 32'h100);
    step(); step();
    step(); redirect = 1'b1; redirect_pc = 32'h200; halt = 1'b1; #1;
    chk("rdh_en", imem_en, 0);
    step(); redirect = 1'b0; halt = 1'b0; restart(32'h200); #1;
    chk("rdh_en_run", imem_en, 1);
    chk("rdh_addr", imem_addr, 10'h80);
    chk("rdh_popped", last_pc, 32'h10C);
    step(); step(); #1;
    chk("rdh_pc", id_pc, 32'h200);
    step(); halt = 1'b1;
    step(); halt = 1'b0; #1;
    chk("halt_en", imem_en, 0);
    step();
    step(); #1;
    chk("halt_valid", id_valid, 0);
    chk("halt_en2", imem_en, 0);
    chk("halt_last", last_pc, 32'h20C);
    step(); redirect = 1'b1; redirect_pc = 32'h40;
    step(); redirect = 1'b0; restart(32'h40); #1;
    chk("resume_en", imem_en, 1);
    chk("resume_addr", imem_addr, 10'h10);
    step(); step(); #1;
    chk("resume_pc", id_pc, 32'h40);
    step();
    step(); redirect = 1'b1; redirect_pc = 32'h102; #1;
    chk("mis_pre", misalign, 0);
    step(); redirect = 1'b0; exp_q.delete(); #1;
    chk("mis_flag", misalign, 1);
    chk("mis_en", imem_en, 0);
    chk("mis_valid", id_valid, 0);
    chk("mis_addr", imem_addr, 10'h14);
    chk("mis_last", last_pc, 32'h48);
    repeat (2) begin
      step(); #1;
      chk("mis_sticky", misalign, 1);
      chk("mis_no_fetch", imem_en, 0);
    end
    step(); redirect = 1'b1; redirect_pc = 32'h80;
    step(); redirect = 1'b0; restart(32'h80); id_ready = 1'b0;
    step(); step(); step(); #1;
    chk("full_pc", id_pc, 32'h80);
    rst = 1'b0; #1;
    reset_vals();
    id_ready = 1'b1;
    step(); step();
    restart(32'h0);
    boot();
    step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step(); redirect = 1'b0; restart(32'hFFFF_FFF8); #1;
    chk("wrap_en", imem_en, 1);
    chk("wrap_addr0", imem_addr, 10'h3FE);
    step(); #1;
    chk("wrap_addr1", imem_addr, 10'h3FF);
    step(); #1;
    chk("wrap_pc0", id_pc, 32'hFFFF_FFF8);
    chk("wrap_addr2", imem_addr, 10'h000);
    step(); #1;
    chk("wrap_pc1", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", id_pc4, 32'h0);
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the MIPS32 core. It owns the fetch PC and drives the synchronous-read instruction memory (AddrMem). It presents fetched instructions to the ID stage through a valid/ready handshake. A 2-entry queue absorbs the memory's read latency so that ID back-pressure, branch/jump redirects and halt requests never drop or duplicate an instruction.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- IMEM_AW, 10: instruction-memory word-address width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- imem_en  out  1  read request this cycle.
- imem_addr  out  IMEM_AW  word address, equal to fpc[IMEM_AW+1:2].
- imem_q  in  32  read data, valid in the cycle after a cycle with imem_en=1.
- id_valid  out  1  head entry holds an instruction.
- id_ready  in  1  ID accepts the head entry. A transfer (pop) occurs when id_valid & id_ready.
- id_inst  out  32  head instruction.
- id_pc  out  32  address of the head instruction.
- id_pc4  out  32  id_pc + 4, modulo 2^32.
- redirect  in  1  branch/jump taken; flush and restart the fetch.
- redirect_pc  in  32  target of the redirect.
- halt  in  1  stop issuing new fetches.
- misalign  out  1  sticky flag: a redirect was seen with redirect_pc[1:0] != 0.

## Operation
- **State machine:** BOOT, RUN, HALT.
  - BOOT → RUN unconditionally after one cycle.
  - RUN → HALT when halt=1 and redirect=0.
  - HALT → RUN on an accepted redirect. halt is ignored in HALT.
- **Fetch PC (fpc):** reset value is RESET_PC. fpc increments by 4 on every issued request.
- **Queue:** 2-entry FIFO of {pc, inst}. The head drives id_inst, id_pc and id_pc4.
  - Data returned by the memory is enqueued at the end of the cycle after its request, tagged with the pc of that request.
- **Issue rule:** imem_en = (state==RUN) & !redirect & (count + inflight - pop < 2).
  - inflight is 1 when imem_en was 1 in the previous cycle and no flush has occurred since.
  - This rule is the only overflow guard. The queue never exceeds 2 entries.
- **Accepted redirect:** redirect=1 and redirect_pc[1:0]==0, in any state. A pop in the same cycle completes first. Then:
  - the queue is cleared;
  - inflight is cleared, and the returning imem_q is discarded;
  - fpc is set to redirect_pc;
  - state becomes RUN.
- **Misaligned redirect:** redirect=1 and redirect_pc[1:0]!=0.
  - misalign is set and stays set until reset.
  - The queue and inflight are flushed.
  - State goes to HALT and fpc is unchanged.
- **Halt:**
  - In HALT, no requests are issued.
  - The queue and any in-flight read drain normally to ID.
  - id_valid drops once the queue is empty.
- **Address wrap:** fpc wraps modulo 2^32. imem_addr is a truncated slice, so the memory wraps at 2^IMEM_AW words without any error.

## Timing
- **Reset values:**
  - imem_en=0, imem_addr=RESET_PC[IMEM_AW+1:2].
  - id_valid=0, id_inst=0, id_pc=0, id_pc4=0.
  - misalign=0, state=BOOT, queue empty, inflight=0.
- **Reset mid-operation:** all registers return to their reset values asynchronously. Any in-flight data is discarded.
- **Boot sequence:**
  - First cycle after rst rises (c0): BOOT, imem_en=0.
  - c1: imem_en=1, imem_addr=RESET_PC>>2.
  - c2: imem_q valid; captured into the queue at the end of c2.
  - c3: id_valid=1.
- **Load-to-use latency:** 2 cycles from imem_en to id_valid.
- **Steady state:** with id_ready held at 1, one instruction transfers per cycle with consecutive PCs.
- **Back-pressure:** id_valid, id_inst and id_pc hold stable while id_ready=0. A stall causes at most one extra read (the in-flight one), which lands in the second queue entry.
- **Redirect latency:**
  - Redirect in cycle t.
  - Target fetched in t+1.
  - id_valid with id_pc=redirect_pc in t+3 at the earliest.
  - id_valid=0 in t+1 and t+2.
- **Redirect with simultaneous pop:** the head is consumed and all other entries are flushed.
- **Redirect with simultaneous halt:** the redirect wins; state becomes RUN.

## Test plan
- **Boot:** release rst with RESET_PC=0 and id_ready=1.
  - imem_en first goes high in c1 at addr 0.
  - id_valid=1 in c3 with id_pc=0 and id_pc4=4.
  - Thereafter id_pc steps 4, 8, 12, … one per cycle.
- **Back-pressure:** drop id_ready for 3 cycles while streaming at pc 0x10.
  - id_pc holds 0x10 and imem_en is 0 once the queue is full.
  - On release, 0x10, 0x14, 0x18 appear in order with no gap or duplicate.
- **Redirect during stall:** queue full, id_ready=0, redirect to 0x100.
  - Queue is flushed; id_valid=0 for 2 cycles.
  - Next head is 0x100; no stale pc appears.
- **Halt and resume:** assert halt while streaming.
  - Remaining queued and in-flight instructions drain, then id_valid=0 and imem_en=0.
  - redirect to 0x40 resumes fetching at 0x40.
- **Misaligned redirect:** redirect_pc=0x102.
  - misalign=1 and stays set.
  - State is HALT, no further imem_en, pipeline flushed.
- **Reset mid-operation:** assert rst with a full queue.
  - All outputs return to their reset values immediately.
  - After release, the boot sequence repeats exactly.
